dmem_bridge: RTL

Data-memory bus bridge sitting directly downstream of the CPU pipeline's memory stage. It takes the MEM-stage load/store request (address, write data, write enable), runs a request/acknowledge transaction on an external word-wide data bus with variable latency, and stalls the pipeline until the access completes. It also provides timeout abort and misalignment detection, and returns load data to the MEM/WB register.

---
 rtl/dmem_bridge_if.sv | 18 +
 rtl/dmem_bridge.sv | 81 ++++++++
 2 files changed

// File: rtl/dmem_bridge_if.sv
// dmem_bridge_if: word-wide request/acknowledge data-memory bus between the bridge and memory.
//   req   : request, held high for the whole transaction (bridge -> memory)
//   we    : write enable, valid with req (bridge -> memory)
//   addr  : word address, [1:0] always zero (bridge -> memory)
//   wdata : store data, valid with req (bridge -> memory)
//   ack   : one-cycle completion strobe (memory -> bridge)
//   rdata : load data, valid with ack (memory -> bridge)
interface dmem_bridge_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/dmem_bridge.sv
// dmem_bridge: MEM-stage load/store to request/acknowledge bus bridge with stall, timeout and misalignment error.
//   clk, rst_n  : clock, asynchronous active-low reset
//   MemReadM    : load present in MEM stage
//   MemWriteM   : store present in MEM stage (wins when both are high)
//   ALUOutM     : byte address
//   WriteDataM  : store data
//   ReadDataM   : load result, valid in DONE, held otherwise
//   StallM      : combinational pipeline hold
//   DmemErr     : sticky error (timeout or misaligned), cleared only by reset
//   bus         : master side of the data bus (registered req/we/addr/wdata)
module dmem_bridge #(
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [31:0]       ALUOutM,
    input  logic [31:0]       WriteDataM,
    output logic [31:0]       ReadDataM,
    output logic              StallM,
    output logic              DmemErr,
    dmem_bridge_if.master     bus
);
    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t     state;
    logic [7:0] cnt;
    logic       access;

    assign access = MemReadM | MemWriteM;
    // DONE never stalls, so the instruction in MEM advances on the DONE edge
    // and the following IDLE cycle sees the next instruction.
    assign StallM = (state == IDLE) ? access : (state == BUS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            ReadDataM <= '0;
            DmemErr   <= 1'b0;
            bus.req   <= 1'b0;
            bus.we    <= 1'b0;
            bus.addr  <= '0;
            bus.wdata <= '0;
        end else begin
            case (state)
                IDLE: if (access) begin
                    if (ALUOutM[1:0] == 2'b00) begin
                        state     <= BUS;
                        cnt       <= '0;
                        bus.req   <= 1'b1;
                        bus.we    <= MemWriteM;
                        bus.addr  <= {ALUOutM[31:2], 2'b00};
                        bus.wdata <= WriteDataM;
                    end else begin
                        state     <= DONE;
                        DmemErr   <= 1'b1;
                        ReadDataM <= '0;
                    end
                end
                BUS: if (bus.ack) begin
                    state     <= DONE;
                    bus.req   <= 1'b0;
                    bus.we    <= 1'b0;
                    ReadDataM <= bus.we ? '0 : bus.rdata;
                end else if (cnt == 8'(TIMEOUT - 1)) begin
                    state     <= DONE;
                    bus.req   <= 1'b0;
                    bus.we    <= 1'b0;
                    ReadDataM <= ERR_DATA;
                    DmemErr   <= 1'b1;
                end else begin
                    cnt <= cnt + 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
